logic_unit_pipe: RTL and testbench

- Parametrised, registered bitwise logic unit. Successor to the single-bit combinational gate block.
- Applies one of eight selectable bitwise ops to WIDTH-bit operands behind a valid/ready handshake.
- Two modes: element-wise (one result per beat) and reduce (folds a multi-beat packet into one result).
- Sits between a stream producer and consumer in lab datapath exercises.

---
 rtl/logic_unit_pkg.sv | 23 ++
 rtl/logic_op_core.sv | 30 +++
 rtl/logic_unit_pipe.sv | 135 +++++++++++++
 tb/tb_logic_unit_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared constants for the registered bitwise logic unit: op codes,
// mode codes and FSM state encodings.
package logic_unit_pkg;

    // Bitwise operation codes presented on OP.
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // Operating modes presented on MODE.
    localparam logic MODE_ELEM   = 1'b0;
    localparam logic MODE_REDUCE = 1'b1;

    // Packet FSM states.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operator: res = x op b. The first operand is A on
// the first beat of a packet and the running accumulator afterwards.
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] res
);

    // Select one of the eight bitwise functions.
    always_comb begin
        res = x;
        case (op)
            OP_AND:  res = x & b;
            OP_OR:   res = x | b;
            OP_NOT:  res = ~x;
            OP_NAND: res = ~(x & b);
            OP_NOR:  res = ~(x | b);
            OP_XOR:  res = x ^ b;
            OP_XNOR: res = ~(x ^ b);
            OP_PASS: res = x;
            default: res = x;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready streams on both sides.
// Element-wise mode produces one result per beat; reduce mode folds a
// multi-beat packet (terminated by LAST) into a single result.
//
// Handshake: a beat transfers on a cycle where IN_VALID && IN_READY; a
// result transfers on a cycle where OUT_VALID && OUT_READY. IN_READY is
// !OUT_VALID || OUT_READY, so a draining result and a new beat may share a
// cycle with no bubble. Output fields hold while OUT_VALID && !OUT_READY.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             MODE,
    input  logic             LAST,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic             Y_ZERO,
    output logic             Y_PAR,
    output logic [CNT_W-1:0] BEATS,
    output logic [0:0]       dbg_state
);

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic [WIDTH-1:0] acc;
    logic [2:0]       pkt_op;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] x_sel;
    logic [2:0]       op_sel;
    logic [WIDTH-1:0] op_res;
    logic             in_fire;
    logic             out_fire;
    logic             emit;

    assign IN_READY  = !OUT_VALID || OUT_READY;
    assign in_fire   = IN_VALID && IN_READY;
    assign out_fire  = OUT_VALID && OUT_READY;
    assign dbg_state = state;

    // Operand steering: first beat uses A and the live OP, later beats use
    // the accumulator and the op latched at packet start.
    always_comb begin
        x_sel  = A;
        op_sel = OP;
        if (state == ST_ACCUM) begin
            x_sel  = acc;
            op_sel = pkt_op;
        end
    end

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x   (x_sel),
        .b   (B),
        .op  (op_sel),
        .res (op_res)
    );

    // Beat count for the value being formed; saturates at all-ones.
    always_comb begin
        cnt_next = CNT_W'(1);
        if (state == ST_ACCUM) begin
            cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
        end
    end

    // Decide whether the accepted beat produces an output and where the FSM goes.
    always_comb begin
        emit       = 1'b0;
        state_next = state;
        if (in_fire) begin
            if (state == ST_IDLE) begin
                if (MODE == MODE_ELEM || LAST) begin
                    emit = 1'b1;
                end else begin
                    state_next = ST_ACCUM;
                end
            end else if (LAST) begin
                emit       = 1'b1;
                state_next = ST_IDLE;
            end
        end
    end

    // Packet state: FSM, accumulator, beat counter and latched op.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            acc    <= '0;
            cnt    <= '0;
            pkt_op <= OP_AND;
        end else begin
            state <= state_next;
            if (in_fire && (state == ST_ACCUM || MODE == MODE_REDUCE)) begin
                acc <= op_res;
                cnt <= cnt_next;
            end
            if (in_fire && state == ST_IDLE) begin
                pkt_op <= OP;
            end
        end
    end

    // Output register: loads on emit, clears valid when drained, else holds.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VALID <= 1'b0;
            Y         <= '0;
            Y_ZERO    <= 1'b1;
            Y_PAR     <= 1'b0;
            BEATS     <= '0;
        end else if (emit) begin
            OUT_VALID <= 1'b1;
            Y         <= op_res;
            Y_ZERO    <= (op_res == '0);
            Y_PAR     <= ^op_res;
            BEATS     <= cnt_next;
        end else if (out_fire) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed steps followed by random traffic,
// with a truth-table reference model and an expected-result queue.
module tb_logic_unit_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int MAX_CNT = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [2:0]       OP = '0;
    logic             MODE = 1'b0;
    logic             LAST = 1'b0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [WIDTH-1:0] Y;
    logic             Y_ZERO;
    logic             Y_PAR;
    logic [CNT_W-1:0] BEATS;
    logic [0:0]       dbg_state;

    logic_unit_pipe #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .OP        (OP),
        .MODE      (MODE),
        .LAST      (LAST),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Y         (Y),
        .Y_ZERO    (Y_ZERO),
        .Y_PAR     (Y_PAR),
        .BEATS     (BEATS),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 CLK = ~CLK;

    // Scoreboard.
    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [CNT_W-1:0] beats;
    } exp_t;
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: per-bit truth tables indexed by {x_bit, b_bit}.
    logic [3:0]       tt [8];
    bit               m_busy = 0;
    logic [WIDTH-1:0] m_acc;
    int               m_cnt;
    logic [2:0]       m_op;
    bit               rand_rdy = 0;

    initial begin
        tt[0] = 4'b1000; // AND
        tt[1] = 4'b1110; // OR
        tt[2] = 4'b0011; // NOT x
        tt[3] = 4'b0111; // NAND
        tt[4] = 4'b0001; // NOR
        tt[5] = 4'b0110; // XOR
        tt[6] = 4'b1001; // XNOR
        tt[7] = 4'b1100; // PASS x
    end

    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic [3:0]       t;
        t = tt[op];
        for (int i = 0; i < WIDTH; i++) r[i] = t[{x[i], b[i]}];
        return r;
    endfunction

    task automatic model_beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [2:0] op, input logic mode, input logic last);
        if (!m_busy) begin
            if (mode == 1'b0) begin
                exp_q.push_back(exp_t'{ref_op(op, a, b), CNT_W'(1)});
            end else begin
                m_op  = op;
                m_acc = ref_op(op, a, b);
                m_cnt = 1;
                if (last) exp_q.push_back(exp_t'{m_acc, CNT_W'(m_cnt)});
                else m_busy = 1;
            end
        end else begin
            m_acc = ref_op(m_op, m_acc, b);
            if (m_cnt < MAX_CNT) m_cnt++;
            if (last) begin
                exp_q.push_back(exp_t'{m_acc, CNT_W'(m_cnt)});
                m_busy = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: present a beat, wait for acceptance (bounded), update model.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] op, input logic mode, input logic last);
        int waited;
        waited = 0;
        A = a; B = b; OP = op; MODE = mode; LAST = last; IN_VALID = 1'b1;
        forever begin
            @(negedge CLK);
            if (IN_READY) break;
            waited++;
            if (waited > 200) begin
                n_vec++;
                n_err++;
                $error("FAIL accept_timeout observed=stalled expected=accepted");
                IN_VALID = 1'b0;
                return;
            end
        end
        model_beat(a, b, op, mode, last);
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
    endtask

    // Asynchronous reset in the middle of activity; checks take effect without a clock edge.
    task automatic reset_mid(input string tag);
        #3 RST_N = 1'b0;
        exp_q.delete();
        m_busy = 0;
        #1;
        chk({tag, "_out_valid"}, OUT_VALID, 1'b0);
        chk({tag, "_y"}, Y, 8'h00);
        chk({tag, "_y_zero"}, Y_ZERO, 1'b1);
        chk({tag, "_y_par"}, Y_PAR, 1'b0);
        chk({tag, "_beats"}, BEATS, 8'd0);
        chk({tag, "_in_ready"}, IN_READY, 1'b1);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Output monitor: every drained result must match the head of the queue.
    always @(negedge CLK) begin
        if (RST_N && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL unexpected_output observed=%0h expected=none", Y);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_y", Y, e.y);
                chk("mon_beats", BEATS, e.beats);
                chk("mon_y_zero", Y_ZERO, e.y == '0);
                chk("mon_y_par", Y_PAR, $countones(e.y) % 2);
            end
        end
    end

    // Random consumer backpressure during the random phase.
    always @(posedge CLK) begin
        if (rand_rdy) begin
            #1 OUT_READY = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int drain;
        // Initial reset.
        repeat (3) @(negedge CLK);
        chk("reset_out_valid", OUT_VALID, 1'b0);
        chk("reset_y_zero", Y_ZERO, 1'b1);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Reset while a result is being held.
        OUT_READY = 1'b0;
        send(8'h5A, 8'h00, 3'd7, 1'b0, 1'b0);
        chk("t1_held_valid", OUT_VALID, 1'b1);
        repeat (2) @(posedge CLK);
        #1;
        reset_mid("t1");

        // Element-wise basics.
        OUT_READY = 1'b1;
        send(8'hA5, 8'h0F, 3'd5, 1'b0, 1'b1);
        chk("t2_xor_y", Y, 8'hAA);
        chk("t2_xor_zero", Y_ZERO, 1'b0);
        chk("t2_xor_par", Y_PAR, 1'b0);
        chk("t2_xor_beats", BEATS, 8'd1);
        send(8'hFF, 8'hFF, 3'd3, 1'b0, 1'b0);
        chk("t2_nand_y", Y, 8'h00);
        chk("t2_nand_zero", Y_ZERO, 1'b1);

        // Backpressure: second beat stalls while the first result is held.
        @(posedge CLK);
        #1 OUT_READY = 1'b0;
        send(8'hC3, 8'hF0, 3'd0, 1'b0, 1'b0);
        fork
            send(8'h0C, 8'h30, 3'd1, 1'b0, 1'b0);
            begin
                repeat (3) @(negedge CLK);
                chk("t3_stall_in_ready", IN_READY, 1'b0);
                chk("t3_held_y", Y, 8'hC0);
                chk("t3_held_valid", OUT_VALID, 1'b1);
                @(posedge CLK);
                #1 OUT_READY = 1'b1;
            end
        join
        chk("t3_second_y", Y, 8'h3C);

        // Reduce XOR packet of three beats.
        send(8'h01, 8'h02, 3'd5, 1'b1, 1'b0);
        chk("t4_no_early_out", OUT_VALID, 1'b0);
        send(8'h00, 8'h04, 3'd5, 1'b1, 1'b0);
        send(8'h00, 8'h08, 3'd5, 1'b1, 1'b1);
        chk("t4_y", Y, 8'h0F);
        chk("t4_beats", BEATS, 8'd3);
        chk("t4_par", Y_PAR, 1'b0);
        // Single-beat packet.
        send(8'hF0, 8'h3C, 3'd0, 1'b1, 1'b1);
        chk("t4_single_y", Y, 8'h30);
        chk("t4_single_beats", BEATS, 8'd1);

        // Latched op: later beats present OR but AND must rule.
        send(8'hF0, 8'hFF, 3'd0, 1'b1, 1'b0);
        send(8'h00, 8'h3C, 3'd1, 1'b0, 1'b0);
        send(8'h00, 8'h30, 3'd1, 1'b0, 1'b1);
        chk("t5_y", Y, 8'h30);
        chk("t5_beats", BEATS, 8'd3);

        // Reset mid-packet, then a clean packet.
        send(8'hFF, 8'h0F, 3'd5, 1'b1, 1'b0);
        send(8'h00, 8'h11, 3'd5, 1'b1, 1'b0);
        reset_mid("t6");
        send(8'h80, 8'h01, 3'd1, 1'b1, 1'b1);
        chk("t6_y", Y, 8'h81);
        chk("t6_beats", BEATS, 8'd1);

        // Beat counter saturation on a long packet.
        for (int i = 0; i < 260; i++) begin
            send(8'($urandom), 8'($urandom), 3'd5, 1'b1, i == 259);
        end
        chk("sat_beats", BEATS, 8'd255);

        // Random traffic with random backpressure.
        rand_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end
        if (m_busy) send(8'($urandom), 8'($urandom), 3'd0, 1'b1, 1'b1);
        rand_rdy = 0;
        @(posedge CLK);
        #2 OUT_READY = 1'b1;

        // Drain, bounded.
        drain = 0;
        while (exp_q.size() != 0 && drain < 50) begin
            @(posedge CLK);
            drain++;
        end
        #1;
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_out_valid", OUT_VALID, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
